// File: rtl/sim_oserdes_framer_pkg.sv
// Shared constants, state encoding and helpers for the serializer-side framer.
// Control words are chosen so that (word ^ ESC_XOR) never lands on another control word.
package sim_serdes_pkg;

    localparam logic [7:0] CW_TRAIN = 8'h5A;
    localparam logic [7:0] CW_IDLE  = 8'hBC;
    localparam logic [7:0] CW_SOF   = 8'hFB;
    localparam logic [7:0] CW_EOF   = 8'hFD;
    localparam logic [7:0] CW_ESC   = 8'h7D;
    localparam logic [7:0] ESC_XOR  = 8'h20;

    typedef enum logic [2:0] {
        ST_TRAIN,
        ST_IDLE,
        ST_DATA,
        ST_ESC2,
        ST_EOF
    } framer_state_t;

    function automatic logic is_ctrl(input logic [7:0] b);
        return (b == CW_TRAIN) || (b == CW_IDLE) || (b == CW_SOF) ||
               (b == CW_EOF)   || (b == CW_ESC);
    endfunction

endpackage

// File: rtl/sim_oserdes_framer_if.sv
// Byte-stream input, training request and serializer-side outputs of the framer.
interface sim_oserdes_framer_if #(
    parameter int FIFO_DEPTH = 8
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_last;
    logic          tx_ready;
    logic          train_req;
    logic [7:0]    data_out_from_device;
    logic          link_trained;
    logic [LW-1:0] fifo_level;

    modport master (
        output tx_data, tx_valid, tx_last, train_req,
        input  tx_ready, data_out_from_device, link_trained, fifo_level
    );

    modport slave (
        input  tx_data, tx_valid, tx_last, train_req,
        output tx_ready, data_out_from_device, link_trained, fifo_level
    );

endinterface

// File: rtl/sim_oserdes_framer_fifo.sv
// Single-clock first-word-fall-through FIFO; pointers carry one extra bit so
// level = wr - rd works across the natural modulo-DEPTH wrap.
module sim_sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;
    logic [AW:0]      w_level;

    assign w_level   = r_wr_ptr - r_rd_ptr;
    assign o_level   = w_level;
    assign o_full    = (w_level == (AW+1)'(DEPTH));
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Head is read combinationally so a popped byte reaches the output register on the pop edge.
    assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sim_oserdes_framer.sv
// Transmit framer on the divided clock: training, idle fill, SOF/EOF framing and
// ESC byte-stuffing of payload that collides with a control word.
module sim_oserdes_framer
    import sim_serdes_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int TRAIN_WORDS = 16
) (
    input  logic                 clk_div_in,
    input  logic                 io_reset,
    sim_oserdes_framer_if.slave  bus
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int CW = $clog2(TRAIN_WORDS + 1);

    framer_state_t r_state;
    framer_state_t w_state_nxt;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_nxt;
    logic          r_pending;
    logic          w_pending_nxt;
    logic          r_link_trained;
    logic          w_link_trained_nxt;
    logic          r_gap;
    logic          w_gap_nxt;
    logic [7:0]    r_hold_data;
    logic [7:0]    w_hold_data_nxt;
    logic          r_hold_last;
    logic          w_hold_last_nxt;
    logic [7:0]    r_data_out;
    logic [7:0]    w_data_out_nxt;

    logic          w_push;
    logic          w_pop;
    logic [8:0]    w_fifo_rd;
    logic          w_full;
    logic          w_empty;
    logic [LW-1:0] w_level;

    assign w_push = bus.tx_valid && !w_full;

    sim_sync_fifo #(
        .WIDTH (9),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk     (clk_div_in),
        .i_rst     (io_reset),
        .i_push    (w_push),
        .i_wr_data ({bus.tx_last, bus.tx_data}),
        .i_pop     (w_pop),
        .o_rd_data (w_fifo_rd),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_level   (w_level)
    );

    always_comb begin
        w_state_nxt        = r_state;
        w_count_nxt        = r_count;
        w_pending_nxt      = r_pending | bus.train_req;
        w_link_trained_nxt = r_link_trained;
        w_gap_nxt          = r_gap;
        w_hold_data_nxt    = r_hold_data;
        w_hold_last_nxt    = r_hold_last;
        w_data_out_nxt     = r_data_out;
        w_pop              = 1'b0;

        case (r_state)
            ST_TRAIN: begin
                w_data_out_nxt = CW_TRAIN;
                if (r_count == CW'(TRAIN_WORDS - 1)) begin
                    w_count_nxt = '0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_count_nxt = r_count + 1'b1;
                end
            end
            ST_IDLE: begin
                w_data_out_nxt = CW_IDLE;
                w_gap_nxt      = 1'b0;
                if (r_pending) begin
                    // Pulses arriving on this edge are absorbed by the retrain being started.
                    w_pending_nxt      = 1'b0;
                    w_link_trained_nxt = 1'b0;
                    w_state_nxt        = ST_TRAIN;
                end else begin
                    w_link_trained_nxt = 1'b1;
                    // r_gap forces one IDLE word between back-to-back frames.
                    if (!r_gap && !w_empty) begin
                        w_data_out_nxt = CW_SOF;
                        w_state_nxt    = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                w_data_out_nxt = CW_IDLE;
                if (!w_empty) begin
                    w_pop = 1'b1;
                    if (is_ctrl(w_fifo_rd[7:0])) begin
                        w_data_out_nxt  = CW_ESC;
                        w_hold_data_nxt = w_fifo_rd[7:0];
                        w_hold_last_nxt = w_fifo_rd[8];
                        w_state_nxt     = ST_ESC2;
                    end else begin
                        w_data_out_nxt = w_fifo_rd[7:0];
                        if (w_fifo_rd[8]) begin
                            w_state_nxt = ST_EOF;
                        end
                    end
                end
            end
            ST_ESC2: begin
                w_data_out_nxt = r_hold_data ^ ESC_XOR;
                w_state_nxt    = r_hold_last ? ST_EOF : ST_DATA;
            end
            ST_EOF: begin
                w_data_out_nxt = CW_EOF;
                w_gap_nxt      = 1'b1;
                w_state_nxt    = ST_IDLE;
            end
            default: begin
                w_count_nxt = '0;
                w_state_nxt = ST_TRAIN;
            end
        endcase
    end

    always_ff @(posedge clk_div_in or posedge io_reset) begin
        if (io_reset) begin
            r_state        <= ST_TRAIN;
            r_count        <= '0;
            r_pending      <= 1'b0;
            r_link_trained <= 1'b0;
            r_gap          <= 1'b0;
            r_hold_data    <= 8'h00;
            r_hold_last    <= 1'b0;
            r_data_out     <= 8'h00;
        end else begin
            r_state        <= w_state_nxt;
            r_count        <= w_count_nxt;
            r_pending      <= w_pending_nxt;
            r_link_trained <= w_link_trained_nxt;
            r_gap          <= w_gap_nxt;
            r_hold_data    <= w_hold_data_nxt;
            r_hold_last    <= w_hold_last_nxt;
            r_data_out     <= w_data_out_nxt;
        end
    end

    assign bus.tx_ready             = !w_full;
    assign bus.data_out_from_device = r_data_out;
    assign bus.link_trained         = r_link_trained;
    assign bus.fifo_level           = w_level;

endmodule

// File: tb/tb_sim_oserdes_framer.sv
// Directed bench for sim_oserdes_framer with TRAIN_WORDS=4, FIFO_DEPTH=8.
// Each step drives {train_req, valid, last, data} and expects {link_trained, word}.
module tb_sim_oserdes_framer;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    sim_oserdes_framer_if #(.FIFO_DEPTH(8)) bus ();

    sim_oserdes_framer #(
        .FIFO_DEPTH  (8),
        .TRAIN_WORDS (4)
    ) dut (
        .clk_div_in (clk),
        .io_reset   (rst),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    function automatic logic [10:0] px(input logic tr, input logic v, input logic l, input logic [7:0] d);
        return {tr, v, l, d};
    endfunction

    localparam logic [10:0] NOP = 11'h000;

    task automatic step(input string tag, input logic [10:0] drv, input logic [8:0] exp);
        bus.train_req = drv[10];
        bus.tx_valid  = drv[9];
        bus.tx_last   = drv[8];
        bus.tx_data   = drv[7:0];
        @(posedge clk);
        #1;
        bus.train_req = 1'b0;
        bus.tx_valid  = 1'b0;
        bus.tx_last   = 1'b0;
        check_vec(tag, {23'd0, bus.link_trained, bus.data_out_from_device}, {23'd0, exp});
    endtask

    logic [7:0] ctrl_tab [5];
    logic [7:0] t4_bytes [20];
    int         idx;
    int         rx;
    int         cyc;
    int         peak;
    bit         will_push;
    bit         in_fr;
    bit         esc_p;
    bit         done;
    bit         seen_full;
    bit         seen_back;
    logic [7:0] w;

    task automatic rx_byte(input logic [7:0] b);
        if (rx < 20) begin
            check_vec($sformatf("t4_byte%0d", rx), {24'd0, b}, {24'd0, t4_bytes[rx]});
        end else begin
            check_vec("t4_extra_byte", rx, 19);
        end
        rx++;
    endtask

    initial begin
        n_vec         = 0;
        n_err         = 0;
        rst           = 1'b1;
        bus.tx_data   = 8'h00;
        bus.tx_valid  = 1'b0;
        bus.tx_last   = 1'b0;
        bus.train_req = 1'b0;
        ctrl_tab[0] = 8'h5A; ctrl_tab[1] = 8'hBC; ctrl_tab[2] = 8'hFB;
        ctrl_tab[3] = 8'hFD; ctrl_tab[4] = 8'h7D;
        for (int i = 0; i < 20; i++) begin
            t4_bytes[i] = (i % 4 == 3) ? 8'(8'h30 + i) : ctrl_tab[i % 5];
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_vec("rst_data",  bus.data_out_from_device, 8'h00);
        check_vec("rst_lt",    bus.link_trained, 0);
        check_vec("rst_ready", bus.tx_ready, 1);
        check_vec("rst_level", bus.fifo_level, 0);
        rst = 1'b0;

        // Training after reset release
        for (int i = 0; i < 4; i++) step("t1_train", NOP, 9'h05A);
        step("t1_idle", NOP, 9'h1BC);
        step("t1_idle", NOP, 9'h1BC);

        // Plain frame 01 02 03
        step("t2", px(0, 1, 0, 8'h01), 9'h1BC);
        step("t2", px(0, 1, 0, 8'h02), 9'h1FB);
        step("t2", px(0, 1, 1, 8'h03), 9'h101);
        step("t2", NOP, 9'h102);
        step("t2", NOP, 9'h103);
        step("t2", NOP, 9'h1FD);
        step("t2", NOP, 9'h1BC);

        // Escaped frame FB 7D
        step("t3", px(0, 1, 0, 8'hFB), 9'h1BC);
        step("t3", px(0, 1, 1, 8'h7D), 9'h1FB);
        step("t3", NOP, 9'h17D);
        step("t3", NOP, 9'h1DB);
        step("t3", NOP, 9'h17D);
        step("t3", NOP, 9'h15D);
        step("t3", NOP, 9'h1FD);
        step("t3", NOP, 9'h1BC);

        // Underrun inside a frame: three IDLE fillers
        step("t5", px(0, 1, 0, 8'h11), 9'h1BC);
        step("t5", px(0, 1, 0, 8'h22), 9'h1FB);
        step("t5", NOP, 9'h111);
        step("t5", NOP, 9'h122);
        step("t5", NOP, 9'h1BC);
        step("t5", NOP, 9'h1BC);
        step("t5", px(0, 1, 0, 8'h33), 9'h1BC);
        step("t5", px(0, 1, 1, 8'h44), 9'h133);
        step("t5", NOP, 9'h144);
        step("t5", NOP, 9'h1FD);
        step("t5", NOP, 9'h1BC);

        // Training request mid-frame: frame finishes, then retrain
        step("t6", px(0, 1, 0, 8'hAA), 9'h1BC);
        step("t6", px(1, 1, 1, 8'hBB), 9'h1FB);
        step("t6", NOP, 9'h1AA);
        step("t6", NOP, 9'h1BB);
        step("t6", NOP, 9'h1FD);
        step("t6", NOP, 9'h0BC);
        for (int i = 0; i < 4; i++) step("t6_train", NOP, 9'h05A);
        step("t6_idle", NOP, 9'h1BC);

        // Reset mid-frame
        step("t7", px(0, 1, 0, 8'h01), 9'h1BC);
        step("t7", px(0, 1, 0, 8'h02), 9'h1FB);
        step("t7", px(0, 1, 0, 8'h03), 9'h101);
        rst = 1'b1;
        #1;
        check_vec("t7_rst_data",  bus.data_out_from_device, 8'h00);
        check_vec("t7_rst_level", bus.fifo_level, 0);
        check_vec("t7_rst_lt",    bus.link_trained, 0);
        check_vec("t7_rst_ready", bus.tx_ready, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) step("t7_train", NOP, 9'h05A);
        step("t7_idle", NOP, 9'h1BC);

        // 20-byte burst pushed during training; mostly escaped so the FIFO fills
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idx = 0; rx = 0; cyc = 0; peak = 0;
        in_fr = 0; esc_p = 0; done = 0; seen_full = 0; seen_back = 0;
        while (!done && cyc < 300) begin
            bus.tx_valid = (idx < 20);
            bus.tx_data  = (idx < 20) ? t4_bytes[idx] : 8'h00;
            bus.tx_last  = (idx == 19);
            will_push    = bus.tx_valid && bus.tx_ready;
            @(posedge clk);
            #1;
            cyc++;
            if (will_push) idx++;
            if (int'(bus.fifo_level) > peak) peak = int'(bus.fifo_level);
            if (!bus.tx_ready && !seen_full) begin
                seen_full = 1;
                check_vec("t4_full_level", bus.fifo_level, 8);
            end else if (seen_full && !seen_back && bus.tx_ready) begin
                seen_back = 1;
                check_vec("t4_ready_back_level", bus.fifo_level, 7);
            end
            w = bus.data_out_from_device;
            if (!in_fr) begin
                if (w == 8'hFB) in_fr = 1;
            end else if (esc_p) begin
                esc_p = 0;
                rx_byte(w ^ 8'h20);
            end else if (w == 8'h7D) begin
                esc_p = 1;
            end else if (w == 8'hFD) begin
                done = 1;
            end else if (w != 8'hBC) begin
                rx_byte(w);
            end
        end
        bus.tx_valid = 1'b0;
        bus.tx_last  = 1'b0;
        check_vec("t4_done",     done, 1);
        check_vec("t4_rx_count", rx, 20);
        check_vec("t4_peak",     peak, 8);
        check_vec("t4_seen_full", seen_full, 1);
        step("t4_tail", NOP, 9'h1BC);
        check_vec("t4_tail_level", bus.fifo_level, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sim_oserdes_framer.md
# sim_oserdes_framer

Simulation-model transmit framer on the slow divided clock, directly upstream of the 8:1 output serializer. It accepts a byte stream with a valid/ready handshake, buffers it in a small FIFO, and drives one 8-bit word per `clk_div_in` cycle onto the serializer's parallel input. Each word is a training word, an idle word, a frame delimiter, an escape, or payload. Control-word collisions in the payload are byte-stuffed, so the receiver can always find frame boundaries.

## Interface
- `FIFO_DEPTH`, 8: payload FIFO entries (9 bits each: data + last); power of 2, at least 2.
- `TRAIN_WORDS`, 16: number of training words sent after reset or a training request; at least 1.
- `clk_div_in`  input  1  slow divided clock, the only clock. All logic uses its rising edge.
- `io_reset`  input  1  asynchronous, active-high reset.
- `tx_data`  input  8  payload byte.
- `tx_valid`  input  1  `tx_data`/`tx_last` valid.
- `tx_last`  input  1  byte is the last of its frame.
- `tx_ready`  output  1  FIFO can accept a byte.
- `train_req`  input  1  single-cycle pulse requesting retraining.
- `data_out_from_device`  output  8  registered word to the serializer.
- `link_trained`  output  1  high once training is complete.
- `fifo_level`  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- Control words: TRAIN=8'h5A, IDLE=8'hBC, SOF=8'hFB, EOF=8'hFD, ESC=8'h7D.
- Escaping: a payload byte equal to any control word is sent as ESC followed by `byte ^ 8'h20`. No escaped value collides with a control word.
- Push: when `tx_valid && tx_ready`. `tx_ready = !full`.
- Pop: occurs only in DATA, and only when the FIFO is not empty. A simultaneous push and pop leaves the level unchanged.
- State machine (all transitions on the rising edge):
  - TRAIN: emit TRAIN and count. After the TRAIN_WORDS-th word, go to IDLE.
  - IDLE: if a training request is pending, go to TRAIN (clears the pending flag and drops `link_trained`). Otherwise, if the FIFO is not empty, emit SOF and go to DATA. Otherwise emit IDLE.
  - DATA, FIFO empty: emit IDLE as filler and stay in DATA.
  - DATA, FIFO not empty: pop one byte. If it is a control word, emit ESC, hold the byte and its last flag, and go to ESC2. Otherwise emit the byte, then go to EOF if last, else stay in DATA.
  - ESC2: emit `held ^ 8'h20`. Go to EOF if the held last flag is set, else DATA.
  - EOF: emit EOF and go to IDLE. At least one IDLE word always separates frames.
- A `train_req` pulse is latched into the pending flag. It takes effect only in IDLE and never splits a frame. Further pulses while pending are absorbed.
- Reset values:
  - outputs: `data_out_from_device`=8'h00, `link_trained`=0, `tx_ready`=1, `fifo_level`=0.
  - internal: FIFO flushed, state=TRAIN, count=0, pending=0.
- Reset mid-frame discards the FIFO and the partial frame. No EOF is sent.

## Timing
- Output is registered and changes only on the `clk_div_in` rising edge.
- First edge after `io_reset` falls: TRAIN appears. TRAIN is held for exactly TRAIN_WORDS cycles, then IDLE.
- `link_trained` rises on the same edge as the first IDLE word after training.
- Latency from a push into an empty FIFO while in IDLE, at edge t:
  - SOF appears at edge t+1.
  - The first payload word (or ESC) appears at edge t+2.
- Payload throughput: 1 byte/cycle unescaped, 2 cycles per escaped byte.
- Full boundary: `tx_ready` is 0 when the level equals FIFO_DEPTH. It returns to 1 the cycle after a pop.
- Pointer wrap is natural modulo FIFO_DEPTH. The level is computed with one extra bit.

## Structure
- Package `sim_serdes_pkg`:
  - the five control-word constants and the ESC_XOR constant 8'h20;
  - the framer state enum (TRAIN, IDLE, DATA, ESC2, EOF);
  - an `is_ctrl(byte)` function.
- Sub-module `sim_sync_fifo`: single-clock FIFO, width 9, depth FIFO_DEPTH, with push/pop/full/empty/level.
- The framer holds the FSM, training counter, pending flag, escape hold register and output register.

## Test plan
- Reset release with TRAIN_WORDS=4 → 4×8'h5A, then 8'hBC continuously; `link_trained` rises on the first 8'hBC.
- Frame {8'h01, 8'h02, 8'h03 (last)} pushed into an idle link → BC, FB, 01, 02, 03, FD, BC.
- Frame {8'hFB, 8'h7D (last)} → FB, 7D, DB, 7D, 5D, FD, BC.
- Hold `tx_valid` with 20 bytes, FIFO_DEPTH=8, while the link is still training → `tx_ready` drops at level 8; all 20 bytes arrive in order with no loss.
- Stop pushing after byte 2 of a 4-byte frame for 3 cycles → three 8'hBC fillers inside the frame, then the remaining bytes and FD.
- `train_req` pulsed mid-frame → the frame completes with FD; then `link_trained`=0 and TRAIN_WORDS×5A, then BC. Asserting `io_reset` mid-frame → output 8'h00 immediately, `fifo_level`=0, then training restarts.
